// File: rtl/register_bus_arbiter.sv
// Round-robin arbiter sharing one register-block port between requesters A and B.
// Transactions are serialised: IDLE -> ISSUE -> (RD_WAIT for reads) -> IDLE.
module register_bus_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              ipClk,
    input  logic              ipReset,
    input  logic              ipA_Valid,
    input  logic              ipA_Write,
    input  logic [ADDR_W-1:0] ipA_Address,
    input  logic [DATA_W-1:0] ipA_WrData,
    output logic              opA_Ready,
    output logic [DATA_W-1:0] opA_RdData,
    output logic              opA_RdValid,
    input  logic              ipB_Valid,
    input  logic              ipB_Write,
    input  logic [ADDR_W-1:0] ipB_Address,
    input  logic [DATA_W-1:0] ipB_WrData,
    output logic              opB_Ready,
    output logic [DATA_W-1:0] opB_RdData,
    output logic              opB_RdValid,
    output logic [ADDR_W-1:0] opAddress,
    output logic [DATA_W-1:0] opWrData,
    output logic              opWrEnable,
    input  logic [DATA_W-1:0] ipRdData
);
    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

    state_t     state;
    logic       lastGrantB;
    logic       ownerB;
    logic       isWrite;
    logic [2:0] waitCnt;
    logic       grantA;
    logic       grantB;

    // On a tie the requester that was not served last wins.
    assign grantA    = ipA_Valid & (~ipB_Valid | lastGrantB);
    assign grantB    = ipB_Valid & (~ipA_Valid | ~lastGrantB);
    assign opA_Ready = (state == IDLE) & grantA;
    assign opB_Ready = (state == IDLE) & grantB;

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            state       <= IDLE;
            lastGrantB  <= 1'b1;
            ownerB      <= 1'b0;
            isWrite     <= 1'b0;
            waitCnt     <= '0;
            opAddress   <= '0;
            opWrData    <= '0;
            opWrEnable  <= 1'b0;
            opA_RdData  <= '0;
            opA_RdValid <= 1'b0;
            opB_RdData  <= '0;
            opB_RdValid <= 1'b0;
        end else begin
            opWrEnable  <= 1'b0;
            opA_RdValid <= 1'b0;
            opB_RdValid <= 1'b0;
            case (state)
                IDLE: begin
                    // Bus registers are loaded at acceptance so they are valid throughout ISSUE.
                    if (opA_Ready || opB_Ready) begin
                        ownerB     <= opB_Ready;
                        lastGrantB <= opB_Ready;
                        isWrite    <= opB_Ready ? ipB_Write   : ipA_Write;
                        opAddress  <= opB_Ready ? ipB_Address : ipA_Address;
                        opWrData   <= opB_Ready ? ipB_WrData  : ipA_WrData;
                        opWrEnable <= opB_Ready ? ipB_Write   : ipA_Write;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (isWrite) begin
                        state <= IDLE;
                    end else begin
                        waitCnt <= LAT;
                        state   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (waitCnt <= 3'd1) begin
                        if (ownerB) begin
                            opB_RdData  <= ipRdData;
                            opB_RdValid <= 1'b1;
                        end else begin
                            opA_RdData  <= ipRdData;
                            opA_RdValid <= 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        waitCnt <= waitCnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_register_bus_arbiter.sv
// Scoreboard bench: two arbiter instances (read latency 1 and 3) each driving a small register model.
module tb_register_bus_arbiter;
    logic ipClk = 1'b0;
    logic ipReset = 1'b0;
    always #5 ipClk = ~ipClk;

    logic        valid [2][2];
    logic        write [2][2];
    logic [7:0]  addr  [2][2];
    logic [31:0] wdata [2][2];
    logic        ready [2][2];
    logic [31:0] rdata [2][2];
    logic        rvalid[2][2];
    logic [7:0]  busAddr  [2];
    logic [31:0] busWrData[2];
    logic        busWe    [2];
    logic [31:0] rdIn     [2];

    int cyc = 0;
    always @(posedge ipClk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : gInst
        localparam int L = (g == 0) ? 1 : 3;

        register_bus_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LATENCY(L)) dut (
            .ipClk(ipClk), .ipReset(ipReset),
            .ipA_Valid(valid[g][0]), .ipA_Write(write[g][0]), .ipA_Address(addr[g][0]),
            .ipA_WrData(wdata[g][0]), .opA_Ready(ready[g][0]), .opA_RdData(rdata[g][0]),
            .opA_RdValid(rvalid[g][0]),
            .ipB_Valid(valid[g][1]), .ipB_Write(write[g][1]), .ipB_Address(addr[g][1]),
            .ipB_WrData(wdata[g][1]), .opB_Ready(ready[g][1]), .opB_RdData(rdata[g][1]),
            .opB_RdValid(rvalid[g][1]),
            .opAddress(busAddr[g]), .opWrData(busWrData[g]), .opWrEnable(busWe[g]),
            .ipRdData(rdIn[g])
        );

        // Register model: read data is valid only in the single cycle L after ISSUE, poison otherwise.
        logic [31:0] mem [256];
        logic [31:0] pipe[L];
        logic        tag [L];
        logic        issueQ = 1'b0;
        logic        loaded = 1'b0;

        always @(posedge ipClk) begin
            if (!loaded) begin
                for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
                mem[0] <= 32'h11111111;
                mem[1] <= 32'h0000000A;
                mem[2] <= 32'h22222222;
                mem[3] <= 32'h33333333;
                for (int k = 0; k < L; k++) begin
                    tag[k]  <= 1'b0;
                    pipe[k] <= 32'h0;
                end
                loaded <= 1'b1;
            end else begin
                if (busWe[g]) mem[busAddr[g]] <= busWrData[g];
                pipe[0] <= mem[busAddr[g]];
                tag[0]  <= issueQ;
                for (int k = L - 1; k > 0; k--) begin
                    pipe[k] <= pipe[k-1];
                    tag[k]  <= tag[k-1];
                end
            end
            issueQ <= ipReset & ((valid[g][0] & ready[g][0]) | (valid[g][1] & ready[g][1]));
        end
        assign rdIn[g] = tag[L-1] ? pipe[L-1] : 32'hBAD0BAD0;
    end

    typedef struct {int inst; int req; logic [31:0] data; int due;} rd_t;
    typedef struct {int inst; logic [7:0] addr; logic [31:0] data; int due;} wr_t;
    rd_t rdQ[$];
    wr_t wrQ[$];
    int nCmp = 0;
    int nBad = 0;

    // Monitor: pops and checks whenever a DUT presents RdValid or a write strobe.
    always @(negedge ipClk) begin : mon
        rd_t e;
        wr_t w;
        if (ipReset) begin
            for (int i = 0; i < 2; i++) begin
                if (ready[i][0] || ready[i][1]) begin
                    nCmp++;
                    if (ready[i][0] && ready[i][1]) begin
                        nBad++;
                        $display("FAIL ready_onehot inst%0d: got both ready, want at most one", i);
                    end
                end
                for (int r = 0; r < 2; r++) begin
                    if (rvalid[i][r]) begin
                        nCmp++;
                        if (rdQ.size() == 0) begin
                            nBad++;
                            $display("FAIL rdvalid_unexpected inst%0d req%0d cyc%0d: got data %h, want no rdvalid",
                                     i, r, cyc, rdata[i][r]);
                        end else begin
                            e = rdQ.pop_front();
                            if (e.inst != i || e.req != r || e.data !== rdata[i][r] || e.due != cyc) begin
                                nBad++;
                                $display("FAIL rd_result: got inst%0d req%0d data %h cyc%0d, want inst%0d req%0d data %h cyc%0d",
                                         i, r, rdata[i][r], cyc, e.inst, e.req, e.data, e.due);
                            end
                        end
                    end
                end
                if (busWe[i]) begin
                    nCmp++;
                    if (wrQ.size() == 0) begin
                        nBad++;
                        $display("FAIL wr_unexpected inst%0d cyc%0d: got addr %h data %h, want no write",
                                 i, cyc, busAddr[i], busWrData[i]);
                    end else begin
                        w = wrQ.pop_front();
                        if (w.inst != i || w.addr !== busAddr[i] || w.data !== busWrData[i] || w.due != cyc) begin
                            nBad++;
                            $display("FAIL wr_strobe: got inst%0d addr %h data %h cyc%0d, want inst%0d addr %h data %h cyc%0d",
                                     i, busAddr[i], busWrData[i], cyc, w.inst, w.addr, w.data, w.due);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge ipClk);
        #1;
    endtask

    // Presents a request, waits (bounded) for Ready, records the expected bus/read outcome.
    task automatic doReq(input int i, input int r, input bit wr, input logic [7:0] a,
                         input logic [31:0] d, input logic [31:0] expRd, input bit track,
                         input bit drop, output int tAcc);
        bit got = 1'b0;
        write[i][r] = wr;
        addr[i][r]  = a;
        wdata[i][r] = d;
        valid[i][r] = 1'b1;
        tAcc = -1;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge ipClk);
            if (ready[i][r]) got = 1'b1;
        end
        if (!got) begin
            nCmp++;
            nBad++;
            $display("FAIL accept_timeout inst%0d req%0d: got no ready, want ready within 40 cycles", i, r);
            valid[i][r] = 1'b0;
            return;
        end
        tAcc = cyc;
        if (track) begin
            if (wr) wrQ.push_back('{i, a, d, cyc + 1});
            else    rdQ.push_back('{i, r, expRd, cyc + ((i == 0) ? 1 : 3) + 2});
        end
        @(posedge ipClk);
        #1;
        if (drop) valid[i][r] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ta, tb, w1, w2, w3, t;
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < 2; r++) begin
                valid[i][r] = 1'b0;
                write[i][r] = 1'b0;
                addr[i][r]  = 8'h0;
                wdata[i][r] = 32'h0;
            end
        ipReset = 1'b0;
        repeat (3) @(posedge ipClk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_addr", 32'(busAddr[i]), 32'h0);
            chk("rst_wrdata", busWrData[i], 32'h0);
            chk("rst_we", 32'(busWe[i]), 32'h0);
            chk("rst_rdvalid", {30'h0, rvalid[i][1], rvalid[i][0]}, 32'h0);
            chk("rst_rddata_a", rdata[i][0], 32'h0);
        end
        @(negedge ipClk);
        ipReset = 1'b1;
        idle(2);

        // Single write from A; Ready must fall once in ISSUE even with Valid still high.
        doReq(0, 0, 1'b1, 8'h02, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0, t);
        chk("t1_ready_low_in_issue", 32'(ready[0][0]), 32'h0);
        valid[0][0] = 1'b0;
        idle(4);

        // Single read from B.
        doReq(0, 1, 1'b0, 8'h01, 32'h0, 32'h0000000A, 1'b1, 1'b1, t);
        idle(5);

        // Simultaneous reads: A wins (last grant was B), B follows at A's T+3.
        fork
            doReq(0, 0, 1'b0, 8'h00, 32'h0, 32'h11111111, 1'b1, 1'b1, ta);
            doReq(0, 1, 1'b0, 8'h02, 32'h0, 32'hDEADBEEF, 1'b1, 1'b1, tb);
        join
        chk("t3_b_after_a", 32'(tb - ta), 32'd3);
        idle(5);
        chk("t3_a_rddata_hold", rdata[0][0], 32'h11111111);
        chk("t3_b_rddata", rdata[0][1], 32'hDEADBEEF);

        // A solo read makes A the last grant, so the next tie goes to B.
        doReq(0, 0, 1'b0, 8'h03, 32'h0, 32'h33333333, 1'b1, 1'b1, t);
        idle(5);
        fork
            doReq(0, 0, 1'b0, 8'h03, 32'h0, 32'h33333333, 1'b1, 1'b1, ta);
            doReq(0, 1, 1'b0, 8'h01, 32'h0, 32'h0000000A, 1'b1, 1'b1, tb);
        join
        chk("t3_rr_a_after_b", 32'(ta - tb), 32'd3);
        idle(5);

        // Back-to-back writes with Valid held high.
        doReq(0, 0, 1'b1, 8'h02, 32'd1, 32'h0, 1'b1, 1'b0, w1);
        doReq(0, 0, 1'b1, 8'h02, 32'd2, 32'h0, 1'b1, 1'b0, w2);
        doReq(0, 0, 1'b1, 8'h02, 32'd3, 32'h0, 1'b1, 1'b1, w3);
        chk("t4_gap12", 32'(w2 - w1), 32'd2);
        chk("t4_gap23", 32'(w3 - w2), 32'd2);
        idle(4);

        // Reset during RD_WAIT: the in-flight read must never report.
        doReq(0, 0, 1'b0, 8'h02, 32'h0, 32'h0, 1'b0, 1'b1, t);
        idle(1);
        ipReset = 1'b0;
        #1;
        chk("t5_we_in_reset", 32'(busWe[0]), 32'h0);
        chk("t5_rdvalid_in_reset", 32'(rvalid[0][0]), 32'h0);
        chk("t5_addr_in_reset", 32'(busAddr[0]), 32'h0);
        repeat (2) @(posedge ipClk);
        @(negedge ipClk);
        ipReset = 1'b1;
        idle(6);
        doReq(0, 0, 1'b0, 8'h02, 32'h0, 32'd3, 1'b1, 1'b1, t);
        idle(5);

        // Read latency 3 instance.
        doReq(1, 0, 1'b0, 8'h03, 32'h0, 32'h33333333, 1'b1, 1'b1, t);
        idle(8);

        chk("queues_drained", 32'(rdQ.size() + wrQ.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule

// File: doc/register_bus_arbiter.md
Name: register_bus_arbiter

Overview:
Shares the single memory-mapped register interface (8-bit address, 32-bit write data, write enable, registered read data) between two requesters: A (host/UART bridge) and B (on-chip sequencer). Transactions are serialised with round-robin arbitration. The block drives the register block's address, write-data and write-enable inputs and returns read data to whichever requester issued the read. It sits between the requesters and the register block.

Parameters:
ADDR_W, 8, address width
DATA_W, 32, data width
RD_LATENCY, 1, cycles from address presented to register read data valid (1..7)

Ports:
ipClk  in  1  system clock
ipReset  in  1  asynchronous, active-low reset
ipA_Valid  in  1  requester A holds a transaction
ipA_Write  in  1  1 = write, 0 = read
ipA_Address  in  ADDR_W  A target address
ipA_WrData  in  DATA_W  A write data
opA_Ready  out  1  A transaction accepted this cycle (combinational)
opA_RdData  out  DATA_W  A read result
opA_RdValid  out  1  one-cycle pulse: opA_RdData valid
ipB_Valid, ipB_Write, ipB_Address, ipB_WrData, opB_Ready, opB_RdData, opB_RdValid  as for A
opAddress  out  ADDR_W  to register block address
opWrData  out  DATA_W  to register block write data
opWrEnable  out  1  to register block write enable
ipRdData  in  DATA_W  from register block read data

Behaviour:
- Reset (ipReset=0, asynchronous): state IDLE; all outputs 0; LastGrant=B, so A wins the first tie. Any in-flight transaction is dropped; no RdValid is issued for it.
- Handshake: a transfer occurs when X_Valid=1 and opX_Ready=1 in the same cycle. Requesters hold Valid and fields stable until accepted. Valid must not be withdrawn before acceptance.
- opX_Ready = (State==IDLE) & grant to X. At most one Ready is high in any cycle.
- Grant: only A valid -> A. Only B valid -> B. Both valid -> the requester not equal to LastGrant. LastGrant updates on every acceptance.
- FSM:
  - IDLE: on acceptance, latch Write, Address, WrData and owner; go to ISSUE.
  - ISSUE (1 cycle): opAddress/opWrData = latched values; opWrEnable = latched Write. A write returns to IDLE. A read loads the wait counter with RD_LATENCY and goes to RD_WAIT.
  - RD_WAIT: the counter decrements each cycle. When it reaches 1, sample ipRdData into opOwner_RdData, assert opOwner_RdValid for the next cycle only, and go to IDLE.
- Timing, RD_LATENCY=1 (accept in cycle T):
  - Write: opWrEnable high in T+1; next acceptance is possible in T+2.
  - Read: address on the bus in T+1; ipRdData sampled in T+2; RdValid high in T+3, together with IDLE.
  - Sustained throughput: one write per 2 cycles, one read per 3 cycles.
- opWrEnable is high only in ISSUE for writes and is registered (never combinational from inputs).
- opAddress and opWrData hold their last values outside ISSUE, so the register block keeps a stable read mux.
- opX_RdData holds until that requester's next read completes. It is not cleared on RdValid falling.
- Non-owner RdValid stays 0. A and B RdValid are never high in the same cycle.
- A requester may present its next request while its RdValid is high. It is accepted the same cycle if granted.
- Invalid ipReset glitches are out of scope. Reset deassertion is synchronised by the system reset block.

Test Plan:
1. A write 0x02 data 0xDEADBEEF, B idle -> opA_Ready pulse at T; opAddress=0x02, opWrData=0xDEADBEEF, opWrEnable=1 for exactly cycle T+1; no RdValid.
2. B read 0x01, model returns 0x0000000A one cycle after address -> opB_RdValid pulse at T+3, opB_RdData=0x0000000A; opA_RdValid stays 0.
3. A and B both valid reads (0x00, 0x02) from reset -> A accepted first, B accepted at A's T+3. A second simultaneous pair -> B first (round-robin); each RdData matches its own address.
4. A issues back-to-back writes 0x02 = 1, 2, 3 with Valid held high -> Ready every 2nd cycle; three opWrEnable pulses carrying 1, 2, 3 in order.
5. Reset asserted during RD_WAIT of an A read -> opWrEnable/opA_RdValid 0 immediately; after release, state is IDLE, no stale RdValid, and a new A read completes normally.
6. RD_LATENCY=3, A read -> ipRdData sampled 3 cycles after ISSUE; RdValid at T+5 with the correct data; bench-model data is invalid before that.
